// File: rtl/alu_exec_unit.sv
// alu_exec_unit: buffered, handshaked RV32I integer execution unit with an in-order result FIFO.
// Optional feature macro: ALU_MUL_EN adds a 3-cycle MUL/MULH/MULHSU/MULHU path (IDLE->MUL1->MUL2).
// Ports:
//   clk_in, rst_n_in       clock (rising edge), asynchronous active-low reset
//   rdy_in, flush_in       global enable (0 freezes all state), mispredict flush
//   in_valid/in_ready      issue handshake; in_op/in_pc/in_rs1/in_rs2/in_imm/in_tag operands
//   out_valid/out_ready    CDB handshake; out_result/out_jump_pc/out_jump/out_tag head entry
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter int OP_W       = 6,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             flush_in,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [XLEN-1:0]  in_pc,
    input  logic [XLEN-1:0]  in_rs1,
    input  logic [XLEN-1:0]  in_rs2,
    input  logic [XLEN-1:0]  in_imm,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [XLEN-1:0]  out_jump_pc,
    output logic             out_jump,
    output logic [TAG_W-1:0] out_tag
);
    localparam logic [OP_W-1:0] OP_LUI = OP_W'(0), OP_AUIPC = OP_W'(1), OP_JAL = OP_W'(2),
        OP_JALR = OP_W'(3), OP_BEQ = OP_W'(4), OP_BNE = OP_W'(5), OP_BLT = OP_W'(6),
        OP_BGE = OP_W'(7), OP_BLTU = OP_W'(8), OP_BGEU = OP_W'(9), OP_ADD = OP_W'(10),
        OP_SUB = OP_W'(11), OP_SLL = OP_W'(12), OP_SLT = OP_W'(13), OP_SLTU = OP_W'(14),
        OP_XOR = OP_W'(15), OP_SRL = OP_W'(16), OP_SRA = OP_W'(17), OP_OR = OP_W'(18),
        OP_AND = OP_W'(19), OP_ADDI = OP_W'(20), OP_SLTI = OP_W'(21), OP_SLTIU = OP_W'(22),
        OP_XORI = OP_W'(23), OP_ORI = OP_W'(24), OP_ANDI = OP_W'(25), OP_SLLI = OP_W'(26),
        OP_SRLI = OP_W'(27), OP_SRAI = OP_W'(28);
    localparam int SH_W = $clog2(XLEN);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int CW   = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [XLEN-1:0]  res;
        logic [XLEN-1:0]  jpc;
        logic             jmp;
        logic [TAG_W-1:0] tag;
    } ent_t;

    ent_t            mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_q, rd_q;
    logic [CW-1:0]   cnt_q;
    ent_t            alu_ent, mul_ent, push_ent;
    logic            idle, mul2, is_mul, acc, push, pop;
    logic [XLEN-1:0] op2, pc_imm, pc4, alu_res, alu_jpc;
    logic [SH_W-1:0] shamt;
    logic            imm_op, eq, lt, ltu, tkn, alu_jmp;

    assign imm_op = (in_op >= OP_ADDI) && (in_op <= OP_SRAI);
    assign op2    = imm_op ? in_imm : in_rs2;
    assign shamt  = op2[SH_W-1:0];
    assign pc_imm = in_pc + in_imm;
    assign pc4    = in_pc + XLEN'(4);
    assign eq     = in_rs1 == in_rs2;
    assign lt     = $signed(in_rs1) < $signed(in_rs2);
    assign ltu    = in_rs1 < in_rs2;
    assign tkn    = (in_op == OP_BEQ) ? eq : (in_op == OP_BNE) ? !eq : (in_op == OP_BLT) ? lt :
                    (in_op == OP_BGE) ? !lt : (in_op == OP_BLTU) ? ltu : !ltu;

    always_comb begin
        alu_res = '0;
        alu_jpc = in_pc;
        alu_jmp = 1'b0;
        case (in_op)
            OP_LUI:             alu_res = in_imm;
            OP_AUIPC:           alu_res = pc_imm;
            OP_JAL:             begin alu_res = pc4; alu_jpc = pc_imm; alu_jmp = 1'b1; end
            OP_JALR:            begin alu_res = pc4; alu_jpc = (in_rs1 + in_imm) & ~XLEN'(1); alu_jmp = 1'b1; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU:
                                begin alu_res = XLEN'(tkn); alu_jpc = pc_imm; alu_jmp = tkn; end
            OP_ADD, OP_ADDI:    alu_res = in_rs1 + op2;
            OP_SUB:             alu_res = in_rs1 - op2;
            OP_SLL, OP_SLLI:    alu_res = in_rs1 << shamt;
            OP_SLT, OP_SLTI:    alu_res = XLEN'($signed(in_rs1) < $signed(op2));
            OP_SLTU, OP_SLTIU:  alu_res = XLEN'(in_rs1 < op2);
            OP_XOR, OP_XORI:    alu_res = in_rs1 ^ op2;
            OP_SRL, OP_SRLI:    alu_res = in_rs1 >> shamt;
            OP_SRA, OP_SRAI:    alu_res = $unsigned($signed(in_rs1) >>> shamt);
            OP_OR, OP_ORI:      alu_res = in_rs1 | op2;
            OP_AND, OP_ANDI:    alu_res = in_rs1 & op2;
            default:            alu_res = '0;
        endcase
    end

    assign alu_ent = '{res: alu_res, jpc: alu_jpc, jmp: alu_jmp, tag: in_tag};

`ifdef ALU_MUL_EN
    localparam logic [OP_W-1:0] OP_MUL = OP_W'(29), OP_MULH = OP_W'(30), OP_MULHSU = OP_W'(31),
        OP_MULHU = OP_W'(32);
    typedef enum logic [1:0] {IDLE, MUL1, MUL2} state_t;
    state_t            state_q;
    logic [XLEN-1:0]   ma_q, mb_q, mpc_q;
    logic [OP_W-1:0]   mop_q;
    logic [TAG_W-1:0]  mtag_q;
    logic [2*XLEN-1:0] prod_q, ea, eb;
    assign is_mul = (in_op >= OP_MUL) && (in_op <= OP_MULHU);
    assign idle   = state_q == IDLE;
    assign mul2   = state_q == MUL2;
    // Sign-extend to 2*XLEN so one unsigned multiplier covers every signedness mix.
    assign ea     = {{XLEN{ma_q[XLEN-1] & (mop_q == OP_MULH || mop_q == OP_MULHSU)}}, ma_q};
    assign eb     = {{XLEN{mb_q[XLEN-1] & (mop_q == OP_MULH)}}, mb_q};
    assign mul_ent = '{res: (mop_q == OP_MUL) ? prod_q[XLEN-1:0] : prod_q[2*XLEN-1:XLEN],
                       jpc: mpc_q, jmp: 1'b0, tag: mtag_q};
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            {ma_q, mb_q, mpc_q, mop_q, mtag_q, prod_q} <= '0;
        end else if (rdy_in) begin
            if (flush_in) state_q <= IDLE;
            else case (state_q)
                IDLE: if (acc && is_mul) begin
                    state_q <= MUL1;
                    {ma_q, mb_q, mpc_q, mop_q, mtag_q} <= {in_rs1, in_rs2, in_pc, in_op, in_tag};
                end
                MUL1: begin prod_q <= ea * eb; state_q <= MUL2; end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign is_mul  = 1'b0;
    assign idle    = 1'b1;
    assign mul2    = 1'b0;
    assign mul_ent = '0;
`endif

    // The slot a multiply pushes into is guaranteed: accept required count < depth and
    // no other push can occur until the FSM returns to IDLE.
    assign in_ready = rdy_in && idle && (cnt_q < CW'(FIFO_DEPTH));
    assign out_valid = rdy_in && (cnt_q != '0);
    assign acc      = in_valid && in_ready && !flush_in;
    assign push     = !flush_in && ((acc && !is_mul) || (rdy_in && mul2));
    assign pop      = out_valid && out_ready && !flush_in;
    assign push_ent = mul2 ? mul_ent : alu_ent;
    assign {out_result, out_jump_pc, out_jump, out_tag} = mem_q[rd_q];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else if (rdy_in) begin
            if (flush_in) begin
                wr_q  <= '0;
                rd_q  <= '0;
                cnt_q <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_q] <= push_ent;
                    wr_q        <= wr_q + PW'(1);
                end
                if (pop) rd_q <= rd_q + PW'(1);
                cnt_q <= cnt_q + CW'(push) - CW'(pop);
            end
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed-vector self-checking bench for alu_exec_unit.
module tb_alu_exec_unit;
    localparam logic [5:0] LUI = 6'd0, AUIPC = 6'd1, JAL = 6'd2, JALR = 6'd3, BLT = 6'd6,
        BLTU = 6'd8, ADD = 6'd10, SLTU = 6'd14, SRA = 6'd17, SLTI = 6'd21, MUL = 6'd29,
        MULH = 6'd30, BAD = 6'd63;

    logic        clk_in = 1'b0, rst_n_in = 1'b0, rdy_in = 1'b1, flush_in = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_jump;
    logic [5:0]  in_op = '0;
    logic [31:0] in_pc = '0, in_rs1 = '0, in_rs2 = '0, in_imm = '0, out_result, out_jump_pc;
    logic [4:0]  in_tag = '0, out_tag;
    int          n_chk = 0, n_err = 0;

    alu_exec_unit dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_pc(in_pc),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_jump_pc(out_jump_pc), .out_jump(out_jump), .out_tag(out_tag)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #200000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [5:0] op, input logic [31:0] pc, rs1, rs2, imm, input logic [4:0] tag);
        {in_op, in_pc, in_rs1, in_rs2, in_imm, in_tag} = {op, pc, rs1, rs2, imm, tag};
        in_valid = 1'b1;
        @(posedge clk_in);
        #1 in_valid = 1'b0;
    endtask

    task automatic pop1();
        out_ready = 1'b1;
        @(posedge clk_in);
        #1 out_ready = 1'b0;
    endtask

    task automatic run1(input string nm, input logic [5:0] op, input logic [31:0] pc, rs1, rs2, imm,
                        input logic [4:0] tag, input logic [31:0] er, ejpc, input logic ej);
        issue(op, pc, rs1, rs2, imm, tag);
        chk({nm, ".valid"}, out_valid, 1);
        chk({nm, ".result"}, out_result, er);
        chk({nm, ".jump_pc"}, out_jump_pc, ejpc);
        chk({nm, ".jump"}, out_jump, ej);
        chk({nm, ".tag"}, out_tag, tag);
        pop1();
        chk({nm, ".empty"}, out_valid, 0);
    endtask

    initial begin
        #1;
        chk("rst.out_valid", out_valid, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.result", out_result, 0);
        chk("rst.jump_pc", out_jump_pc, 0);
        chk("rst.jump", out_jump, 0);
        chk("rst.tag", out_tag, 0);
        #11 rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        run1("add",   ADD,   32'h200,      32'd7,        32'hFFFF_FFFD, 32'h0,         5'd4,  32'd4,         32'h200,       1'b0);
        run1("bltu",  BLTU,  32'h100,      32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFF8, 5'd1,  32'd1,         32'hF8,        1'b1);
        run1("blt",   BLT,   32'h100,      32'd1,        32'hFFFF_FFFF, 32'hFFFF_FFF8, 5'd2,  32'd0,         32'hF8,        1'b0);
        run1("jalr",  JALR,  32'h40,       32'h1003,     32'h0,         32'd4,         5'd3,  32'h44,        32'h1006,      1'b1);
        run1("jal",   JAL,   32'hFFFF_FFFC, 32'h0,       32'h0,         32'd8,         5'd5,  32'h0,         32'h4,         1'b1);
        run1("sra",   SRA,   32'h10,       32'h8000_0000, 32'h24,       32'h0,         5'd6,  32'hF800_0000, 32'h10,        1'b0);
        run1("sltu",  SLTU,  32'h14,       32'd1,        32'hFFFF_FFFF, 32'h0,         5'd7,  32'd1,         32'h14,        1'b0);
        run1("slti",  SLTI,  32'h18,       32'hFFFF_FFFF, 32'd5,        32'h0,         5'd8,  32'd1,         32'h18,        1'b0);
        run1("lui",   LUI,   32'h1C,       32'd9,        32'd9,         32'h1234_5000, 5'd9,  32'h1234_5000, 32'h1C,        1'b0);
        run1("auipc", AUIPC, 32'h1000,     32'h0,        32'h0,         32'h2000,      5'd10, 32'h3000,      32'h1000,      1'b0);
        run1("bad",   BAD,   32'h2000,     32'd3,        32'd4,         32'd5,         5'd11, 32'h0,         32'h2000,      1'b0);
`ifdef ALU_MUL_EN
        issue(MULH, 32'h80, 32'hFFFF_FFFE, 32'd3, 32'h0, 5'd12);
        chk("mul.busy1", in_ready, 0);
        @(posedge clk_in);
        #1;
        chk("mul.busy2", in_ready, 0);
        chk("mul.notyet", out_valid, 0);
        @(posedge clk_in);
        #1;
        chk("mul.valid", out_valid, 1);
        chk("mul.result", out_result, 32'hFFFF_FFFF);
        chk("mul.tag", out_tag, 12);
        chk("mul.ready", in_ready, 1);
        pop1();
`else
        run1("mul_unknown", MUL, 32'h300, 32'd5, 32'd6, 32'h0, 5'd12, 32'h0, 32'h300, 1'b0);
`endif
        issue(ADD, 32'h0, 32'd1, 32'd1, 32'h0, 5'd1);
        issue(ADD, 32'h0, 32'd1, 32'd1, 32'h0, 5'd2);
        chk("full.in_ready", in_ready, 0);
        chk("full.head", out_tag, 1);
        in_valid = 1'b1;
        in_tag = 5'd3;
        out_ready = 1'b1;
        #1 chk("full.no_passthru", in_ready, 0);
        @(posedge clk_in);
        #1 {in_valid, out_ready} = 2'b00;
        chk("full.second", out_tag, 2);
        chk("full.ready_again", in_ready, 1);
        pop1();
        chk("full.drained", out_valid, 0);
        issue(ADD, 32'h0, 32'd2, 32'd2, 32'h0, 5'd5);
        issue(ADD, 32'h0, 32'd2, 32'd2, 32'h0, 5'd6);
        {flush_in, in_valid, out_ready} = 3'b111;
        in_tag = 5'd9;
        @(posedge clk_in);
        #1 {flush_in, in_valid, out_ready} = 3'b000;
        chk("flush.out_valid", out_valid, 0);
        chk("flush.in_ready", in_ready, 1);
        run1("postflush", ADD, 32'h44, 32'd10, 32'd20, 32'h0, 5'd7, 32'd30, 32'h44, 1'b0);
        issue(ADD, 32'h0, 32'd3, 32'd3, 32'h0, 5'd10);
        rdy_in = 1'b0;
        #1;
        chk("stall.out_valid", out_valid, 0);
        chk("stall.in_ready", in_ready, 0);
        {in_valid, out_ready} = 2'b11;
        in_tag = 5'd11;
        @(posedge clk_in);
        #1 {in_valid, out_ready, rdy_in} = 3'b001;
        #1;
        chk("stall.held", out_valid, 1);
        chk("stall.tag", out_tag, 10);
        pop1();
        chk("stall.none_taken", out_valid, 0);
        issue(ADD, 32'h0, 32'd4, 32'd4, 32'h0, 5'd13);
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst.out_valid", out_valid, 0);
        chk("arst.tag", out_tag, 0);
        chk("arst.in_ready", in_ready, 1);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
